// File: rtl/pcie_egress_segmenter.sv
// Splits a host DMA job into MPS/MRRS/4KB-bounded TLPs and issues them one at a time to the builder.
// Strobe to first enable is 2 cycles; each TLP is held until the builder finishes, and the next one follows 2 cycles after finished falls.
module pcie_egress_segmenter #(
  parameter logic [7:0] TAG_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_job_stb,
  input  logic        i_job_write,
  input  logic [63:0] i_job_address,
  input  logic [23:0] i_job_dword_cnt,
  input  logic [2:0]  i_mps_sel,
  input  logic [2:0]  i_mrrs_sel,
  output logic        o_job_busy,
  output logic        o_job_done,
  output logic [15:0] o_tlp_count,
  output logic        o_egress_enable,
  input  logic        i_egress_finished,
  output logic [7:0]  o_egress_command,
  output logic [63:0] o_egress_address,
  output logic [9:0]  o_egress_dword_cnt,
  output logic [7:0]  o_egress_tag,
  output logic [10:0] o_seg_dword_cnt,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_addr;
  logic [23:0] r_remaining;
  logic        r_write;
  logic [10:0] r_maxsz;
  logic [7:0]  r_tag_ctr;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_tlp_count;
  logic        r_enable;
  logic [7:0]  r_cmd;
  logic [63:0] r_egr_addr;
  logic [7:0]  r_egr_tag;
  logic [10:0] r_seg;

  logic [10:0] w_boundary;
  logic [10:0] w_lim;
  logic [10:0] w_seg;
  logic        w_hi;
  logic [63:0] w_next_addr;

  // Size encoding: 32 << sel dwords, anything above 5 clamps to 1024.
  function automatic logic [10:0] sel_to_sz(input logic [2:0] sel);
    logic [2:0] s;
    s = (sel > 3'd5) ? 3'd5 : sel;
    return 11'd32 << s;
  endfunction

  // Dwords left before the next 4 KB boundary: 1..1024.
  assign w_boundary  = 11'd1024 - {1'b0, r_addr[11:2]};
  assign w_lim       = (r_maxsz < w_boundary) ? r_maxsz : w_boundary;
  assign w_seg       = (r_remaining < {13'd0, w_lim}) ? r_remaining[10:0] : w_lim;
  assign w_hi        = |r_addr[63:32];
  assign w_next_addr = r_addr + {51'd0, r_seg, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_job_stb) begin
          w_next = (i_job_dword_cnt == 24'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC:      w_next = S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_egress_finished) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!i_egress_finished) begin
          w_next = (r_remaining == {13'd0, r_seg}) ? S_DONE : S_CALC;
        end
      end
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 64'd0;
      r_remaining <= 24'd0;
      r_write     <= 1'b0;
      r_maxsz     <= 11'd0;
      r_tag_ctr   <= TAG_BASE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tlp_count <= 16'd0;
      r_enable    <= 1'b0;
      r_cmd       <= 8'd0;
      r_egr_addr  <= 64'd0;
      r_egr_tag   <= 8'd0;
      r_seg       <= 11'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_job_stb) begin
            r_addr      <= i_job_address & ~64'h3;
            r_remaining <= i_job_dword_cnt;
            r_write     <= i_job_write;
            r_maxsz     <= i_job_write ? sel_to_sz(i_mps_sel) : sel_to_sz(i_mrrs_sel);
            r_busy      <= 1'b1;
            r_tlp_count <= 16'd0;
          end
        end
        S_CALC: begin
          r_seg      <= w_seg;
          r_egr_addr <= r_addr;
          r_cmd      <= {1'b0, r_write, w_hi, 5'd0};
          r_egr_tag  <= r_tag_ctr;
          // Raised here so it is already high while in ISSUE.
          r_enable   <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (i_egress_finished) begin
            r_enable <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!i_egress_finished) begin
            r_addr      <= w_next_addr;
            r_remaining <= r_remaining - {13'd0, r_seg};
            if (r_tlp_count != 16'hFFFF) begin
              r_tlp_count <= r_tlp_count + 16'd1;
            end
            if (!r_write) begin
              r_tag_ctr <= r_tag_ctr + 8'd1;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_job_busy         = r_busy;
  assign o_job_done         = r_done;
  assign o_tlp_count        = r_tlp_count;
  assign o_egress_enable    = r_enable;
  assign o_egress_command   = r_cmd;
  assign o_egress_address   = r_egr_addr;
  assign o_egress_dword_cnt = r_seg[9:0];
  assign o_egress_tag       = r_egr_tag;
  assign o_seg_dword_cnt    = r_seg;
  assign o_state            = r_state;

endmodule

// File: tb/tb_pcie_egress_segmenter.sv
// Directed bench for pcie_egress_segmenter with a simple builder handshake model.
module tb_pcie_egress_segmenter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_job_stb = 1'b0;
  logic        i_job_write = 1'b0;
  logic [63:0] i_job_address = 64'd0;
  logic [23:0] i_job_dword_cnt = 24'd0;
  logic [2:0]  i_mps_sel = 3'd0;
  logic [2:0]  i_mrrs_sel = 3'd0;
  logic        o_job_busy;
  logic        o_job_done;
  logic [15:0] o_tlp_count;
  logic        o_egress_enable;
  logic        i_egress_finished = 1'b0;
  logic [7:0]  o_egress_command;
  logic [63:0] o_egress_address;
  logic [9:0]  o_egress_dword_cnt;
  logic [7:0]  o_egress_tag;
  logic [10:0] o_seg_dword_cnt;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_egress_segmenter #(.TAG_BASE(8'h00)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_job_stb         (i_job_stb),
    .i_job_write       (i_job_write),
    .i_job_address     (i_job_address),
    .i_job_dword_cnt   (i_job_dword_cnt),
    .i_mps_sel         (i_mps_sel),
    .i_mrrs_sel        (i_mrrs_sel),
    .o_job_busy        (o_job_busy),
    .o_job_done        (o_job_done),
    .o_tlp_count       (o_tlp_count),
    .o_egress_enable   (o_egress_enable),
    .i_egress_finished (i_egress_finished),
    .o_egress_command  (o_egress_command),
    .o_egress_address  (o_egress_address),
    .o_egress_dword_cnt(o_egress_dword_cnt),
    .o_egress_tag      (o_egress_tag),
    .o_seg_dword_cnt   (o_seg_dword_cnt),
    .o_state           (o_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic wr, input logic [63:0] addr, input logic [23:0] cnt,
                           input logic [2:0] mps, input logic [2:0] mrrs);
    i_job_write     = wr;
    i_job_address   = addr;
    i_job_dword_cnt = cnt;
    i_mps_sel       = mps;
    i_mrrs_sel      = mrrs;
    i_job_stb       = 1'b1;
    tick();
    i_job_stb       = 1'b0;
  endtask

  // Builder model: wait for enable, check the segment, complete the handshake.
  task automatic serve(input string tag, input logic [7:0] cmd, input logic [63:0] addr,
                       input logic [10:0] len, input logic chk_tag, input logic [7:0] tagv);
    int n;
    n = 0;
    while (!o_egress_enable && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_en"}, o_egress_enable, 1);
    chk({tag, "_cmd"}, o_egress_command, cmd);
    chk({tag, "_addr"}, o_egress_address, addr);
    chk({tag, "_cnt"}, o_egress_dword_cnt, len[9:0]);
    chk({tag, "_seg"}, o_seg_dword_cnt, len);
    if (chk_tag) chk({tag, "_tag"}, o_egress_tag, tagv);
    i_egress_finished = 1'b1;
    n = 0;
    while (o_egress_enable && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_endrop"}, o_egress_enable, 0);
    i_egress_finished = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag, input logic [15:0] cnt);
    int n;
    n = 0;
    while (!o_job_done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, o_job_done, 1);
    chk({tag, "_busy"}, o_job_busy, 0);
    chk({tag, "_tlps"}, o_tlp_count, cnt);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_en", o_egress_enable, 0);
    chk("rst_busy", o_job_busy, 0);
    chk("rst_done", o_job_done, 0);
    chk("rst_state", o_state, 0);
    chk("rst_tlps", o_tlp_count, 0);
    chk("rst_cmd", o_egress_command, 0);
    chk("rst_addr", o_egress_address, 0);
    rst_n = 1'b1;
    tick();

    // Write 0x1000, 64 dw, MPS 32: two MWR32 of 32 dw; a strobe while busy is ignored.
    start_job(1'b1, 64'h1000, 24'd64, 3'd0, 3'd5);
    chk("t1_busy", o_job_busy, 1);
    chk("t1_en_n1", o_egress_enable, 0);
    tick();
    chk("t1_latency", o_egress_enable, 1);
    start_job(1'b0, 64'h5000, 24'd3, 3'd5, 3'd5);
    serve("t1a", 8'h40, 64'h1000, 11'd32, 1'b0, 8'h00);
    serve("t1b", 8'h40, 64'h1080, 11'd32, 1'b0, 8'h00);
    wait_done("t1", 16'd2);

    // Read 0xFF8, 8 dw, MRRS 128: split at the 4 KB boundary, tags 0 then 1.
    start_job(1'b0, 64'hFF8, 24'd8, 3'd0, 3'd2);
    serve("t2a", 8'h00, 64'hFF8, 11'd2, 1'b1, 8'h00);
    serve("t2b", 8'h00, 64'h1000, 11'd6, 1'b1, 8'h01);
    wait_done("t2", 16'd2);

    // 64-bit address, then a job crossing 4 GB (low address bits ignored).
    start_job(1'b1, 64'h1_0000_0000, 24'd1, 3'd0, 3'd0);
    serve("t3a", 8'h60, 64'h1_0000_0000, 11'd1, 1'b0, 8'h00);
    wait_done("t3a", 16'd1);
    start_job(1'b1, 64'hFFFF_FFFF, 24'd2, 3'd0, 3'd0);
    serve("t3b", 8'h40, 64'hFFFF_FFFC, 11'd1, 1'b0, 8'h00);
    serve("t3c", 8'h60, 64'h1_0000_0000, 11'd1, 1'b0, 8'h00);
    wait_done("t3b", 16'd2);

    // Zero-length job: done two cycles after the strobe, no TLP.
    start_job(1'b1, 64'h3000, 24'd0, 3'd0, 3'd0);
    chk("t4_done_n1", o_job_done, 0);
    chk("t4_busy_n1", o_job_busy, 1);
    chk("t4_en_n1", o_egress_enable, 0);
    tick();
    chk("t4_done_n2", o_job_done, 1);
    chk("t4_busy_n2", o_job_busy, 0);
    chk("t4_en_n2", o_egress_enable, 0);
    chk("t4_tlps", o_tlp_count, 0);
    tick();
    chk("t4_done_n3", o_job_done, 0);

    // 1024 dw read at a 4 KB-aligned address with MRRS 1024: single TLP, length encoded as 0.
    start_job(1'b0, 64'h2000, 24'd1024, 3'd0, 3'd5);
    serve("t5", 8'h00, 64'h2000, 11'd1024, 1'b1, 8'h02);
    wait_done("t5", 16'd1);

    // Asynchronous reset while waiting on the builder.
    start_job(1'b0, 64'h4000, 24'd4, 3'd0, 3'd0);
    tick();
    chk("t6_en", o_egress_enable, 1);
    tick();
    chk("t6_wait_state", o_state, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", o_egress_enable, 0);
    chk("t6_rst_busy", o_job_busy, 0);
    chk("t6_rst_state", o_state, 0);
    rst_n = 1'b1;
    tick();
    start_job(1'b0, 64'h8000, 24'd4, 3'd0, 3'd0);
    serve("t6b", 8'h00, 64'h8000, 11'd4, 1'b1, 8'h00);
    wait_done("t6b", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
